// File: rtl/sa_psum_writeback_if.sv
// Partial-sum beat in, requantized pixel out, between the conv array and the feature-map store.
interface sa_psum_writeback_if #(
  parameter int ADDR_W = 13,
  parameter int PSUM_W = 24,
  parameter int OUT_W  = 8
);
  logic                     psum_valid;
  logic [ADDR_W-1:0]        psum_addr;
  logic signed [PSUM_W-1:0] psum_data;
  logic                     first_ch;
  logic                     last_ch;
  logic                     last_data;
  logic                     out_valid;
  logic [ADDR_W-1:0]        out_addr;
  logic signed [OUT_W-1:0]  out_data;

  modport master (
    output psum_valid, psum_addr, psum_data, first_ch, last_ch, last_data,
    input  out_valid, out_addr, out_data
  );
  modport slave (
    input  psum_valid, psum_addr, psum_data, first_ch, last_ch, last_data,
    output out_valid, out_addr, out_data
  );
endinterface

// File: rtl/sa_psum_writeback.sv
// Accumulates partial sums per output address across input channels, requantizes on the last one.
// Optional SA_WB_RELU_EN clamps negative emitted pixels to zero (buffer keeps the raw sum).
module sa_psum_writeback #(
  parameter int ADDR_W       = 13,
  parameter int DEPTH        = 4096,
  parameter int PSUM_W       = 24,
  parameter int ACC_W        = 32,
  parameter int OUT_W        = 8,
  parameter int SHIFT        = 8,
  parameter int INVALID_ADDR = 7878
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  sa_psum_writeback_if.slave    bus,
  output logic                  busy,
  output logic                  done
);
  localparam int AW     = $clog2(DEPTH);
  localparam int STAGES = 2;
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic signed [ACC_W-1:0] Q_MAX   = ACC_W'((2**(OUT_W-1)) - 1);
  localparam logic signed [ACC_W-1:0] Q_MIN   = ~Q_MAX;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [PSUM_W-1:0] data;
    logic              first;
    logic              last;
  } beat_t;

  state_t                  state;
  logic                    armed;
  logic [STAGES-1:0]       vld_pipe;   // [0]=S0, [1]=S1
  beat_t                   s0, s1;
  logic signed [ACC_W-1:0] mem [DEPTH];
  logic signed [ACC_W-1:0] rd_data;
  logic                    w1_v, w2_v;
  logic [ADDR_W-1:0]       w1_addr, w2_addr;
  logic signed [ACC_W-1:0] w1_sum, w2_sum;
  logic signed [ACC_W-1:0] old, base, sum, q;
  logic signed [ACC_W:0]   wide;
  logic [OUT_W-1:0]        q_out;
  logic                    accept, abort, wr_en;

  assign abort  = !start && (state == RUN || state == DRAIN);
  assign accept = state == RUN && start && bus.psum_valid &&
                  bus.psum_addr != ADDR_W'(INVALID_ADDR) &&
                  {1'b0, bus.psum_addr} < (ADDR_W+1)'(DEPTH);
  assign wr_en  = vld_pipe[1] && !abort;

  // RAM read in S0 misses writes landing at the same edge; newest forwarded sum wins.
  always_comb begin
    old = rd_data;
    if (w2_v && w2_addr == s1.addr) old = w2_sum;
    if (w1_v && w1_addr == s1.addr) old = w1_sum;
    base = s1.first ? '0 : old;
    wide = $signed({base[ACC_W-1], base}) + (ACC_W+1)'($signed(s1.data));
    if (wide[ACC_W] != wide[ACC_W-1]) sum = wide[ACC_W] ? ACC_MIN : ACC_MAX;
    else                              sum = wide[ACC_W-1:0];
    q = sum >>> SHIFT;
    if (q > Q_MAX)      q_out = {1'b0, {(OUT_W-1){1'b1}}};
    else if (q < Q_MIN) q_out = {1'b1, {(OUT_W-1){1'b0}}};
    else                q_out = q[OUT_W-1:0];
`ifdef SA_WB_RELU_EN
    if (q_out[OUT_W-1]) q_out = '0;
`endif
  end

  always_ff @(posedge clk) begin
    rd_data <= mem[s0.addr[AW-1:0]];
    if (wr_en) mem[s1.addr[AW-1:0]] <= sum;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe     <= '0;
      s0           <= '0;
      s1           <= '0;
      w1_v         <= 1'b0;
      w2_v         <= 1'b0;
      w1_addr      <= '0;
      w2_addr      <= '0;
      w1_sum       <= '0;
      w2_sum       <= '0;
      bus.out_valid <= 1'b0;
      bus.out_addr  <= ADDR_W'(INVALID_ADDR);
      bus.out_data  <= '0;
    end else begin
      vld_pipe <= abort ? '0 : {vld_pipe[0], accept};
      if (accept) s0 <= '{bus.psum_addr, bus.psum_data, bus.first_ch, bus.last_ch};
      s1       <= s0;
      w1_v     <= wr_en;
      w1_addr  <= s1.addr;
      w1_sum   <= sum;
      w2_v     <= w1_v;
      w2_addr  <= w1_addr;
      w2_sum   <= w1_sum;
      bus.out_valid <= wr_en && s1.last;
      if (wr_en && s1.last) begin
        bus.out_addr <= s1.addr;
        bus.out_data <= q_out;
      end
    end
  end

  // armed requires start to be seen low before a new frame may begin
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      armed <= 1'b1;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (!start) armed <= 1'b1;
      case (state)
        IDLE: if (start && armed) begin
          state <= RUN;
          armed <= 1'b0;
          busy  <= 1'b1;
        end
        RUN: if (!start) begin
          state <= IDLE;
          busy  <= 1'b0;
        end else if (accept && bus.last_data) state <= DRAIN;
        DRAIN: if (!start) begin
          state <= IDLE;
          busy  <= 1'b0;
        end else if (vld_pipe == '0) begin
          state <= DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sa_psum_writeback.sv
// Directed bench for sa_psum_writeback; inputs change and outputs are sampled on the falling edge.
module tb_sa_psum_writeback;
  logic clk = 1'b0;
  logic rst_n, start, busy, done;
  logic [7:0] od;
  int n_chk = 0, n_pass = 0, ov_cnt = 0, done_cnt = 0, n0, n1;

  always #5 clk = ~clk;

  sa_psum_writeback_if #(.ADDR_W(13), .PSUM_W(24), .OUT_W(8)) bus ();

  sa_psum_writeback #(
    .ADDR_W(13), .DEPTH(4096), .PSUM_W(24), .ACC_W(32),
    .OUT_W(8), .SHIFT(8), .INVALID_ADDR(7878)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bus(bus), .busy(busy), .done(done)
  );

  assign od = bus.out_data;

  always begin
    @(posedge clk);
    #1;
    if (bus.out_valid) ov_cnt++;
    if (done) done_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drive(input int a, input int d, input logic f, input logic l, input logic ld);
    bus.psum_valid = 1'b1;
    bus.psum_addr  = 13'(a);
    bus.psum_data  = 24'(d);
    bus.first_ch   = f;
    bus.last_ch    = l;
    bus.last_data  = ld;
  endtask

  task automatic idle_in();
    bus.psum_valid = 1'b0;
    bus.psum_addr  = 13'd7878;
    bus.psum_data  = '0;
    bus.first_ch   = 1'b0;
    bus.last_ch    = 1'b0;
    bus.last_data  = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    idle_in();
    tick(); tick();
    chk("rst_ov", bus.out_valid, 0);
    chk("rst_addr", bus.out_addr, 7878);
    chk("rst_data", od, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    rst_n = 1'b1;
    tick();
    start = 1'b1;
    tick();
    chk("run_busy", busy, 1);

    // single channel: 512 >>> 8 = 2
    drive(5, 512, 1, 1, 0); tick(); idle_in(); tick();
    chk("t1_early", bus.out_valid, 0);
    tick();
    chk("t1_ov", bus.out_valid, 1);
    chk("t1_addr", bus.out_addr, 5);
    chk("t1_data", od, 8'd2);
    tick();
    chk("t1_strobe", bus.out_valid, 0);

    // three spaced channels: 768 >>> 8 = 3, one pixel only
    n0 = ov_cnt;
    drive(9, 256, 1, 0, 0); tick(); idle_in(); tick(); tick();
    drive(9, 256, 0, 0, 0); tick(); idle_in(); tick(); tick();
    drive(9, 256, 0, 1, 0); tick(); idle_in(); tick(); tick();
    chk("t2_cnt", ov_cnt - n0, 1);
    chk("t2_addr", bus.out_addr, 9);
    chk("t2_data", od, 8'd3);

    // back-to-back same address, values pre-scaled by 2^SHIFT: 600 saturates to 127
    drive(3, 25600, 1, 0, 0); tick();
    drive(3, 51200, 0, 0, 0); tick();
    drive(3, 76800, 0, 1, 0); tick(); idle_in(); tick(); tick();
    chk("t3_ov", bus.out_valid, 1);
    chk("t3_sat", od, 8'h7f);
    drive(3, 2560, 1, 0, 0); tick();
    drive(3, 5120, 0, 0, 0); tick();
    drive(3, 7680, 0, 1, 0); tick(); idle_in(); tick(); tick();
    chk("t3_fwd", od, 8'd60);

    // sentinel and out-of-range beats are dropped; 4096 must not alias onto addr 0
    drive(0, 512, 1, 0, 0); tick(); idle_in(); tick(); tick();
    n0 = ov_cnt;
    drive(7878, 25600, 1, 1, 0); tick();
    drive(4096, 25600, 1, 1, 0); tick(); idle_in(); tick(); tick(); tick();
    chk("t4_drop", ov_cnt - n0, 0);
    drive(0, 256, 0, 1, 0); tick(); idle_in(); tick(); tick();
    chk("t4_ov", bus.out_valid, 1);
    chk("t4_addr", bus.out_addr, 0);
    chk("t4_data", od, 8'd3);

    // frame end at addr 195
    n0 = done_cnt;
    drive(195, 256, 1, 1, 1); tick(); idle_in(); tick(); tick();
    chk("t5_ov", bus.out_valid, 1);
    chk("t5_addr", bus.out_addr, 195);
    chk("t5_data", od, 8'd1);
    chk("t5_busy_hi", busy, 1);
    chk("t5_done_early", done, 0);
    tick();
    chk("t5_done", done, 1);
    chk("t5_busy_lo", busy, 0);
    tick();
    chk("t5_done_cnt", done_cnt - n0, 1);

    // start still high: no re-entry
    n0 = ov_cnt;
    drive(7, 512, 1, 1, 0); tick(); idle_in(); tick(); tick(); tick();
    chk("t5_no_reentry", ov_cnt - n0, 0);
    chk("t5_idle_busy", busy, 0);
    start = 1'b0; tick();
    start = 1'b1; tick();
    chk("t5_restart", busy, 1);

    // abort one cycle after an accepted last_ch beat
    n0 = ov_cnt;
    n1 = done_cnt;
    drive(50, 512, 1, 1, 0); tick(); idle_in();
    start = 1'b0;
    tick(); tick(); tick();
    chk("t6_no_ov", ov_cnt - n0, 0);
    chk("t6_no_done", done_cnt - n1, 0);
    chk("t6_idle", busy, 0);
    start = 1'b1; tick();
    drive(60, -512, 1, 1, 0); tick(); idle_in(); tick(); tick();
    chk("t6_neg_ov", bus.out_valid, 1);
`ifdef SA_WB_RELU_EN
    chk("t6_neg_data", od, 8'h00);
`else
    chk("t6_neg_data", od, 8'hfe);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/sa_psum_writeback.md
Name: sa_psum_writeback

Overview:
- Downstream stage of the systolic-array address controller.
- Consumes each partial sum from the conv array together with its output address, and accumulates it across input channels in an internal accumulation buffer.
- On the last input channel it requantizes the sum and emits one output pixel for the feature-map store.
- Signals frame completion when the controller's last_data has been written and the pipeline is drained.

Parameters:
ADDR_W, 13, width of output/accumulator address
DEPTH, 4096, accumulation buffer words (covers 64x64 output map)
PSUM_W, 24, signed partial-sum width from array
ACC_W, 32, signed accumulator width
OUT_W, 8, signed requantized output width
SHIFT, 8, arithmetic right shift applied at requantization
INVALID_ADDR, 7878, sentinel address meaning "no data this cycle"

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous, active-low reset
start  in  1  level; high for the whole frame, low aborts/idles
psum_valid  in  1  partial sum present this cycle
psum_addr  in  ADDR_W  output address of partial sum
psum_data  in  PSUM_W  signed partial sum
first_ch  in  1  first input channel: overwrite, do not accumulate
last_ch  in  1  last input channel: requantize and emit
last_data  in  1  qualifies the final address of the frame
out_valid  out  1  one-cycle strobe, output pixel valid
out_addr  out  ADDR_W  address of emitted pixel
out_data  out  OUT_W  requantized pixel
busy  out  1  high in RUN or DRAIN
done  out  1  one-cycle pulse at frame end

Behaviour:
- Reset values: out_valid=0, out_addr=INVALID_ADDR, out_data=0, busy=0, done=0. FSM resets to IDLE and pipeline valids clear. Buffer contents are not reset.
- Accept rule: a beat is accepted only when all of the following hold: state RUN, psum_valid=1, psum_addr!=INVALID_ADDR, psum_addr<DEPTH. Otherwise the beat is dropped silently; no write and no output.
- Pipeline, 3 stages:
  - S0: register the beat and issue the buffer read.
  - S1: read data returns.
  - S2: compute, buffer write, outputs.
- Latency: out_valid is asserted exactly 2 cycles after the accepting edge. Throughput is 1 beat/cycle.
- Compute: base = first_ch ? 0 : old. sum = base + sign-extended psum_data, saturated to the signed ACC_W range.
- Write-back: sum is written to buffer[addr] in S2.
- Hazard forwarding: if the S1 address equals the address being written in S2 this cycle, or written in the previous cycle, old is taken from the forwarded sum (newest first), not from the RAM.
- Requantize when last_ch=1: q = sum >>> SHIFT, saturated to [-2^(OUT_W-1), 2^(OUT_W-1)-1]. Then out_valid=1, out_addr=addr, out_data=q. The buffer is still written.
- When last_ch=0: no output; out_valid=0, and out_addr/out_data hold their previous values.
- first_ch and last_ch both 1 (single channel): overwrite, then emit.
- FSM:
  - IDLE -> RUN on start=1.
  - RUN -> DRAIN when an accepted beat has last_data=1.
  - DRAIN waits until S1 and S2 are empty (2 cycles), then -> DONE.
  - DONE pulses done=1 for one cycle, then -> IDLE.
  - IDLE with start still high does not re-enter RUN. Re-entry requires start to go low, then high again.
- Abort: start=0 in RUN or DRAIN goes to IDLE next cycle. Pipeline valids are flushed, so no out_valid and no buffer write from in-flight beats. done is not pulsed.
- Beats arriving in DRAIN or DONE are dropped.

Optional Feature:
- Macro SA_WB_RELU_EN.
- When defined: at requantization, negative q is clamped to 0 before emit. The buffer always stores the un-clamped sum.
- When undefined: signed q is emitted unchanged.

Test Plan:
- Single channel: start=1, beat addr=5, data=512, first_ch=last_ch=1, SHIFT=8 -> 2 cycles later out_valid=1, out_addr=5, out_data=2.
- Three-channel accumulate: addr 9 with data 256 (first_ch), then 256, then 256 (last_ch), on separate non-adjacent cycles -> single out_data=3 at addr 9.
- Back-to-back same address: addr 3 on consecutive cycles with 100 (first_ch), 200, 300 (last_ch), SHIFT=0 -> out_data saturates to 127. Then rerun with 10, 20, 30 -> out_data=60, proving forwarding.
- Sentinel and range: beats with addr=7878 and addr=4096 -> no out_valid, no buffer change. A subsequent valid beat behaves normally.
- Frame end: last_data with the final beat at addr 195 -> out_valid at +2, done pulse exactly 1 cycle later, busy falls with done.
- Abort: drop start 1 cycle after an accepted last_ch beat -> no out_valid, no done, FSM in IDLE. With SA_WB_RELU_EN, data=-512 with last_ch -> out_data=0; without the macro -> -2.
